// File: rtl/sbus_core_ctl_pkg.sv
// Shared definitions for the MBOX-side SBUS sequencer: FSM states, word-mask type,
// default handshake timeouts and a small mask helper.
package sbus_core_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        XFER,
        DONE
    } tSBUSstate;

    // Bit 0 is word 0 of the quadword, matching the [0:3] numbering of the bus.
    typedef logic [0:3] tWordMask;

    localparam int ACK_TIMEOUT_DEF = 32;
    localparam int DV_TIMEOUT_DEF  = 64;
    localparam int TMR_W           = 16;

    function automatic logic [2:0] mask_popcount(input tWordMask m);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sbus_core_ctl_word_seq.sv
// Quadword word sequencer: from a current word and a word mask, find the first enabled
// word at or after it, the next enabled word strictly after it (mod 4), and the mask popcount.
module sbus_word_seq
    import sbus_core_ctl_pkg::*;
(
    input  logic [1:0] cur_word,
    input  logic [0:3] mask,
    output logic [1:0] first_word,
    output logic [1:0] next_word,
    output logic [2:0] pop_count
);

    logic [1:0] cand [5];
    logic [4:0] hit;

    // Offset 4 wraps back onto cur_word, so a single-word mask still yields itself as next.
    for (genvar gi = 0; gi < 5; gi++) begin : g_cand
        assign cand[gi] = cur_word + 2'(gi);
        assign hit[gi]  = mask[cand[gi]];
    end

    always_comb begin
        first_word = cur_word;
        next_word  = cur_word;
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                first_word = cand[k];
            end
        end
        for (int k = 4; k >= 1; k--) begin
            if (hit[k]) begin
                next_word = cand[k];
            end
        end
    end

    assign pop_count = mask_popcount(tWordMask'(mask));

endmodule

// File: rtl/sbus_core_ctl.sv
// SBUS core sequencer: one quadword read or masked write per request, with NXM timeouts.
// Define SBUS_PARITY_CHECK_EN to check odd parity on every read word (par_err).
module sbus_core_ctl
    import sbus_core_ctl_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int DV_TIMEOUT  = DV_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         CROBAR,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [0:3]   req_rq,
    input  logic [14:35] req_adr,
    input  logic [35:0]  wr_data,
    output logic         wr_take,
    output logic [14:35] sbus_adr,
    output logic         sbus_start,
    output logic         sbus_rd_rq,
    output logic         sbus_wr_rq,
    output logic [0:3]   sbus_rq,
    input  logic         sbus_ackn,
    input  logic         sbus_dv,
    input  logic [35:0]  sbus_d_in,
    input  logic         sbus_d_in_par,
    output logic [35:0]  sbus_d_out,
    output logic [35:0]  rd_data,
    output logic [1:0]   rd_word,
    output logic         core_data_valid,
    output logic         core_data_valm1,
    output logic         core_busy,
    output logic         done,
    output logic         nxm_err,
    output logic         par_err,
    input  logic         err_clr
);

    tSBUSstate        state_reg, state_next;
    logic [14:35]     adr_reg;
    logic             wr_reg;
    tWordMask         rq_reg;
    logic [1:0]       cur_word_reg;
    logic [1:0]       rd_word_reg;
    logic [2:0]       remaining_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic             cdv_reg;
    logic [35:0]      rd_data_reg;
    logic             nxm_reg;

    logic [1:0] seq_cur, seq_first, seq_next;
    logic [2:0] seq_pop;
    tWordMask   seq_mask;
    logic       ack_hit, ack_to, dv_hit, dv_to, last_word, rq_active;

    // While idle the sequencer looks at the incoming request, afterwards at the latched one.
    assign seq_cur  = (state_reg == IDLE) ? req_adr[34:35] : cur_word_reg;
    assign seq_mask = (state_reg == IDLE) ? req_rq : rq_reg;

    sbus_word_seq u_word_seq (
        .cur_word   (seq_cur),
        .mask       (seq_mask),
        .first_word (seq_first),
        .next_word  (seq_next),
        .pop_count  (seq_pop)
    );

    // One timer serves both waits; only one of WAIT_ACK / XFER is ever active.
    assign ack_hit   = (state_reg == WAIT_ACK) && sbus_ackn;
    assign ack_to    = (state_reg == WAIT_ACK) && !sbus_ackn
                       && (tmr_reg == TMR_W'(ACK_TIMEOUT - 1));
    assign dv_hit    = (state_reg == XFER) && sbus_dv;
    assign dv_to     = (state_reg == XFER) && !sbus_dv
                       && (tmr_reg == TMR_W'(DV_TIMEOUT - 1));
    assign last_word = dv_hit && (remaining_reg == 3'd1);
    assign rq_active = (state_reg == START) || (state_reg == WAIT_ACK) || (state_reg == XFER);

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (req_rq == '0) ? DONE : START;
                end
            end
            START:    state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (ack_hit) begin
                    state_next = XFER;
                end else if (ack_to) begin
                    state_next = DONE;
                end
            end
            XFER: begin
                if (last_word || dv_to) begin
                    state_next = DONE;
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_reg == IDLE);
        sbus_start      = (state_reg == START);
        sbus_rd_rq      = rq_active && !wr_reg;
        sbus_wr_rq      = rq_active && wr_reg;
        wr_take         = dv_hit && wr_reg;
        core_data_valm1 = (state_reg == XFER) && (remaining_reg == 3'd1);
        core_busy       = (state_reg != IDLE);
        done            = (state_reg == DONE);
        sbus_d_out      = (rq_active && wr_reg) ? wr_data : '0;
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            adr_reg       <= '0;
            wr_reg        <= 1'b0;
            rq_reg        <= '0;
            cur_word_reg  <= '0;
            rd_word_reg   <= '0;
            remaining_reg <= '0;
            tmr_reg       <= '0;
            cdv_reg       <= 1'b0;
            rd_data_reg   <= '0;
            nxm_reg       <= 1'b0;
        end else begin
            cdv_reg <= dv_hit;
            if (state_reg == IDLE && req_valid) begin
                adr_reg       <= req_adr;
                wr_reg        <= req_wr;
                rq_reg        <= req_rq;
                cur_word_reg  <= seq_first;
                rd_word_reg   <= seq_first;
                remaining_reg <= seq_pop;
            end
            if (state_reg == START || ack_hit || dv_hit) begin
                tmr_reg <= '0;
            end else if (state_reg == WAIT_ACK || state_reg == XFER) begin
                tmr_reg <= tmr_reg + 1'b1;
            end
            if (dv_hit) begin
                remaining_reg <= remaining_reg - 3'd1;
                cur_word_reg  <= seq_next;
                if (!wr_reg) begin
                    rd_data_reg <= sbus_d_in;
                end
            end
            // rd_word holds the strobed word through its pulse, then moves to the next word.
            if (cdv_reg && state_reg == XFER) begin
                rd_word_reg <= cur_word_reg;
            end
            if (ack_to || dv_to) begin
                nxm_reg <= 1'b1;
            end else if (err_clr) begin
                nxm_reg <= 1'b0;
            end
        end
    end

`ifdef SBUS_PARITY_CHECK_EN
    logic par_reg, par_fail;
    assign par_fail = dv_hit && !wr_reg && !(^{sbus_d_in, sbus_d_in_par});

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            par_reg <= 1'b0;
        end else if (par_fail) begin
            par_reg <= 1'b1;
        end else if (err_clr) begin
            par_reg <= 1'b0;
        end
    end

    assign par_err = par_reg;
`else
    logic unused_par;
    assign unused_par = sbus_d_in_par;
    assign par_err    = 1'b0;
`endif

    assign sbus_adr        = adr_reg;
    assign sbus_rq         = rq_reg;
    assign rd_data         = rd_data_reg;
    assign rd_word         = rd_word_reg;
    assign core_data_valid = cdv_reg;
    assign nxm_err         = nxm_reg;

endmodule
